// File: rtl/ram_2port_sync.sv
// Single-clock two-port RAM: port A read/write, port B read-only, both with 1-cycle registered reads.
// A clear engine fills the memory with CLEAR_VALUE after reset or on clear_req. Optional macro: RAM_WRITE_FORWARD_EN.
module ram_2port_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int SIZE       = 8192,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic                  output_enable,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    input  logic                  Q1_READ,
    input  logic [ADDR_WIDTH-1:0] Q1_ADDRESS,
    output logic [DATA_WIDTH-1:0] Q1_DATA_OUT,
    output logic                  Q1_VALID,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int ASPACE = $clog2(SIZE);
    localparam logic [ASPACE-1:0] LAST_PTR = ASPACE'(SIZE - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [ASPACE-1:0]     clear_ptr_r;
    logic [ASPACE-1:0]     clear_ptr_next_s;
    logic                  busy_r;

    logic [DATA_WIDTH-1:0] mem_r [0:SIZE-1];

    logic [ASPACE-1:0]     addr_a_s;
    logic [ASPACE-1:0]     addr_b_s;
    logic                  wr_a_s;
    logic                  rd_a_s;
    logic                  rd_b_s;
    logic                  mem_we_s;
    logic [ASPACE-1:0]     mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [DATA_WIDTH-1:0] q1_rdata_s;

    logic [DATA_WIDTH-1:0] data_out_r;
    logic [DATA_WIDTH-1:0] q1_data_out_r;
    logic                  q1_valid_r;

    // Upper address bits alias modulo SIZE; collect them so they are visibly unused.
    if (ASPACE < ADDR_WIDTH) begin : g_alias
        logic unused_addr_bits_s;
        assign unused_addr_bits_s = ^{ADDRESS[ADDR_WIDTH-1:ASPACE], Q1_ADDRESS[ADDR_WIDTH-1:ASPACE]};
    end

    // Access decode: every port access is suppressed while the clear engine owns the array.
    always_comb begin
        addr_a_s = ADDRESS[ASPACE-1:0];
        addr_b_s = Q1_ADDRESS[ASPACE-1:0];
        wr_a_s   = write_enable  & ~busy_r;
        rd_a_s   = output_enable & ~busy_r;
        rd_b_s   = Q1_READ       & ~busy_r;
    end

    // Clear FSM next-state and pointer logic.
    always_comb begin
        state_next_s     = state_r;
        clear_ptr_next_s = clear_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_next_s     = ST_CLEAR;
                    clear_ptr_next_s = {ASPACE{1'b0}};
                end else begin
                    state_next_s     = ST_IDLE;
                    clear_ptr_next_s = clear_ptr_r;
                end
            end
            ST_CLEAR: begin
                // clear_req is deliberately not looked at here: a running clear never restarts.
                if (clear_ptr_r == LAST_PTR) begin
                    state_next_s     = ST_IDLE;
                    clear_ptr_next_s = {ASPACE{1'b0}};
                end else begin
                    state_next_s     = ST_CLEAR;
                    clear_ptr_next_s = clear_ptr_r + ASPACE'(1'b1);
                end
            end
            default: begin
                state_next_s     = ST_CLEAR;
                clear_ptr_next_s = {ASPACE{1'b0}};
            end
        endcase
    end

    // Clear FSM state, pointer and busy flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            clear_ptr_r <= {ASPACE{1'b0}};
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            clear_ptr_r <= clear_ptr_next_s;
            busy_r      <= (state_next_s == ST_CLEAR);
        end
    end

    // Single array write port shared between the clear engine and port A.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_a_s;
        mem_wdata_s = DATA_IN;
        if (busy_r) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clear_ptr_r;
            mem_wdata_s = CLEAR_VALUE;
        end else if (wr_a_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_a_s;
            mem_wdata_s = DATA_IN;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = addr_a_s;
            mem_wdata_s = DATA_IN;
        end
    end

    // Memory array write; contents are not reset, the clear engine overwrites them.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Port B read data source: stored word, or same-cycle port A write data when forwarding.
    always_comb begin
        q1_rdata_s = mem_r[addr_b_s];
`ifdef RAM_WRITE_FORWARD_EN
        if (wr_a_s && (addr_a_s == addr_b_s)) begin
            q1_rdata_s = DATA_IN;
        end else begin
            q1_rdata_s = mem_r[addr_b_s];
        end
`endif
    end

    // Registered read ports; port A is always read-first against its own write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r    <= {DATA_WIDTH{1'b0}};
            q1_data_out_r <= {DATA_WIDTH{1'b0}};
            q1_valid_r    <= 1'b0;
        end else begin
            if (rd_a_s) begin
                data_out_r <= mem_r[addr_a_s];
            end
            if (rd_b_s) begin
                q1_data_out_r <= q1_rdata_s;
            end
            q1_valid_r <= rd_b_s;
        end
    end

    assign DATA_OUT    = data_out_r;
    assign Q1_DATA_OUT = q1_data_out_r;
    assign Q1_VALID    = q1_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ram_2port_sync.sv
// Directed self-checking bench for ram_2port_sync with SIZE=16.
module tb_ram_2port_sync;

    localparam int DW = 8;
    localparam int AW = 15;
`ifdef RAM_WRITE_FORWARD_EN
    localparam logic [7:0] EXP_Q1_COLLIDE = 8'h77;
`else
    localparam logic [7:0] EXP_Q1_COLLIDE = 8'h11;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          write_enable;
    logic          output_enable;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] DATA_IN;
    logic [DW-1:0] DATA_OUT;
    logic          Q1_READ;
    logic [AW-1:0] Q1_ADDRESS;
    logic [DW-1:0] Q1_DATA_OUT;
    logic          Q1_VALID;
    logic          clear_req;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cnt;

    ram_2port_sync #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SIZE       (16),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .output_enable(output_enable),
        .ADDRESS      (ADDRESS),
        .DATA_IN      (DATA_IN),
        .DATA_OUT     (DATA_OUT),
        .Q1_READ      (Q1_READ),
        .Q1_ADDRESS   (Q1_ADDRESS),
        .Q1_DATA_OUT  (Q1_DATA_OUT),
        .Q1_VALID     (Q1_VALID),
        .clear_req    (clear_req),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        write_enable  = 1'b0;
        output_enable = 1'b0;
        Q1_READ       = 1'b0;
        clear_req     = 1'b0;
    endtask

    task automatic wait_clear_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        ADDRESS = '0;
        Q1_ADDRESS = '0;
        DATA_IN = '0;
        idle_inputs();

        // 1. reset and initial clear
        tick();
        tick();
        check("reset_busy", busy, 1);
        check("reset_dout", DATA_OUT, 8'h00);
        check("reset_q1", Q1_DATA_OUT, 8'h00);
        check("reset_q1v", Q1_VALID, 0);
        reset = 1'b0;
        wait_clear_done(cnt);
        check("init_clear_len", cnt, 16);
        for (int i = 0; i < 16; i++) begin
            Q1_READ = 1'b1;
            Q1_ADDRESS = AW'(i);
            tick();
            check($sformatf("init_q1v_%0d", i), Q1_VALID, 1);
            check($sformatf("init_q1d_%0d", i), Q1_DATA_OUT, 8'h00);
        end
        Q1_READ = 1'b0;
        tick();
        check("q1v_pulse_end", Q1_VALID, 0);

        // 2. write then read on both ports
        write_enable = 1'b1; ADDRESS = 15'h0003; DATA_IN = 8'hA5;
        tick();
        write_enable = 1'b0; output_enable = 1'b1; Q1_READ = 1'b1; Q1_ADDRESS = 15'h0003;
        tick();
        check("t2_dout", DATA_OUT, 8'hA5);
        check("t2_q1", Q1_DATA_OUT, 8'hA5);
        check("t2_q1v", Q1_VALID, 1);
        idle_inputs();
        tick();
        check("t2_q1v_low", Q1_VALID, 0);

        // 3. aliasing of upper address bits
        write_enable = 1'b1; ADDRESS = 15'h0013; DATA_IN = 8'h5A;
        tick();
        write_enable = 1'b0; output_enable = 1'b1; ADDRESS = 15'h0003;
        Q1_READ = 1'b1; Q1_ADDRESS = 15'h7FF3;
        tick();
        check("t3_dout", DATA_OUT, 8'h5A);
        check("t3_q1", Q1_DATA_OUT, 8'h5A);
        idle_inputs();

        // 4. same-cycle write/read collision
        write_enable = 1'b1; ADDRESS = 15'h0005; DATA_IN = 8'h11;
        tick();
        DATA_IN = 8'h77; output_enable = 1'b1; Q1_READ = 1'b1; Q1_ADDRESS = 15'h0005;
        tick();
        check("t4_dout_old", DATA_OUT, 8'h11);
        check("t4_q1_collide", Q1_DATA_OUT, EXP_Q1_COLLIDE);
        write_enable = 1'b0;
        tick();
        check("t4_dout_new", DATA_OUT, 8'h77);
        check("t4_q1_new", Q1_DATA_OUT, 8'h77);
        idle_inputs();

        // 6. no strobes: outputs hold while address/data toggle
        for (int i = 0; i < 4; i++) begin
            ADDRESS = AW'(i * 5 + 1);
            Q1_ADDRESS = AW'(i * 7 + 3);
            DATA_IN = 8'(8'h3C ^ i);
            tick();
            check($sformatf("t6_dout_hold_%0d", i), DATA_OUT, 8'h77);
            check($sformatf("t6_q1_hold_%0d", i), Q1_DATA_OUT, 8'h77);
            check($sformatf("t6_q1v_%0d", i), Q1_VALID, 0);
        end

        // 5. fill with 0xFF, then clear
        for (int i = 0; i < 16; i++) begin
            write_enable = 1'b1; ADDRESS = AW'(i); DATA_IN = 8'hFF;
            tick();
        end
        write_enable = 1'b0; output_enable = 1'b1; ADDRESS = 15'h0002;
        Q1_READ = 1'b1; Q1_ADDRESS = 15'h000F;
        tick();
        check("t5_fill_dout", DATA_OUT, 8'hFF);
        check("t5_fill_q1", Q1_DATA_OUT, 8'hFF);
        idle_inputs();
        clear_req = 1'b1;
        tick();
        check("t5_busy_start", busy, 1);
        // hold write/read strobes and clear_req through the whole clear
        write_enable = 1'b1; ADDRESS = 15'h0002; DATA_IN = 8'h42;
        output_enable = 1'b1; Q1_READ = 1'b1; Q1_ADDRESS = 15'h0002;
        wait_clear_done(cnt);
        idle_inputs();
        check("t5_clear_len", cnt, 16);
        check("t5_dout_hold", DATA_OUT, 8'hFF);
        check("t5_q1_hold", Q1_DATA_OUT, 8'hFF);
        check("t5_q1v_busy", Q1_VALID, 0);
        for (int i = 0; i < 16; i++) begin
            output_enable = 1'b1; ADDRESS = AW'(i);
            Q1_READ = 1'b1; Q1_ADDRESS = AW'(15 - i);
            tick();
            check($sformatf("t5_clr_a_%0d", i), DATA_OUT, 8'h00);
            check($sformatf("t5_clr_b_%0d", 15 - i), Q1_DATA_OUT, 8'h00);
        end
        idle_inputs();

        // 5b. reset in the middle of a clear restarts it
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t5_mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("t5_rst_busy", busy, 1);
        reset = 1'b0;
        wait_clear_done(cnt);
        check("t5_restart_len", cnt, 16);
        check("t5_idle_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
